// File: rtl/axil_req_arbiter.sv
// axil_req_arbiter
// Shares one AXI4-Lite master port between NUM_REQ requesters. It runs one
// single-beat transaction at a time and returns a one-cycle response pulse to
// the requester that issued the command.
// Build option: define AXIL_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest index wins. When the macro is undefined, arbitration is round-robin.
module axil_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [31:0]               resp_rdata,
    output logic [1:0]                resp_code,
    output logic                      busy,
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [31:0]               m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [31:0]               m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [31:0]        wdata_arr [NUM_REQ];

    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   grant_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        wdata_reg;
    logic               awvalid_reg, awvalid_next;
    logic               wvalid_reg, wvalid_next;
    logic               arvalid_reg, arvalid_next;
    logic [NUM_REQ-1:0] resp_valid_reg;
    logic [31:0]        rdata_reg;
    logic [1:0]         code_reg;
    logic               accept;
    logic               wr_done;
    logic               rd_done;

    // Unpack the flattened per-requester operand buses.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
        end
    endgenerate

`ifdef AXIL_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest asserted index wins.
    always_comb begin
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[IDX_W'(k)]) begin
                grant_idx = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_reg;
    logic [IDX_W-1:0] cand_idx;
    logic             grant_found;
    int               cand;

    // Round-robin: scan upward from the pointer with wrap-around. The first
    // asserted request found is granted.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_idx   = cand_idx;
                grant_found = 1'b1;
            end
        end
    end

    // After requester i is granted, requester i+1 gets top priority.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rr_ptr_reg <= '0;
        end else if (accept) begin
            rr_ptr_reg <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, AXI valid next values and the accept and completion strobes.
    always_comb begin
        state_next   = state_reg;
        awvalid_next = awvalid_reg;
        wvalid_next  = wvalid_reg;
        arvalid_next = arvalid_reg;
        req_ready    = '0;
        accept       = 1'b0;
        wr_done      = 1'b0;
        rd_done      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    accept               = 1'b1;
                    req_ready[grant_idx] = 1'b1;
                    if (req_write[grant_idx]) begin
                        state_next   = WR_ADDR_DATA;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                    end else begin
                        state_next   = RD_ADDR;
                        arvalid_next = 1'b1;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently, in either order.
                if (awvalid_reg && m_axi_awready) awvalid_next = 1'b0;
                if (wvalid_reg && m_axi_wready)   wvalid_next  = 1'b0;
                if (!awvalid_next && !wvalid_next) state_next = WR_RESP;
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    wr_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_next = 1'b0;
                    state_next   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rd_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command capture, registered AXI valids and response delivery.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            grant_reg      <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            awvalid_reg    <= 1'b0;
            wvalid_reg     <= 1'b0;
            arvalid_reg    <= 1'b0;
            resp_valid_reg <= '0;
            rdata_reg      <= '0;
            code_reg       <= '0;
        end else begin
            awvalid_reg    <= awvalid_next;
            wvalid_reg     <= wvalid_next;
            arvalid_reg    <= arvalid_next;
            resp_valid_reg <= '0;
            if (accept) begin
                grant_reg <= grant_idx;
                addr_reg  <= addr_arr[grant_idx];
                wdata_reg <= wdata_arr[grant_idx];
            end
            if (wr_done) begin
                resp_valid_reg[grant_reg] <= 1'b1;
                rdata_reg                 <= '0;
                code_reg                  <= m_axi_bresp;
            end
            if (rd_done) begin
                resp_valid_reg[grant_reg] <= 1'b1;
                rdata_reg                 <= m_axi_rdata;
                code_reg                  <= m_axi_rresp;
            end
        end
    end

    assign resp_valid    = resp_valid_reg;
    assign resp_rdata    = rdata_reg;
    assign resp_code     = code_reg;
    assign busy          = (state_reg != IDLE);
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = (state_reg == WR_RESP);
    assign m_axi_araddr  = addr_reg;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = (state_reg == RD_DATA);

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Self-checking bench for axil_req_arbiter (NUM_REQ = 4). A behavioural
// AXI4-Lite slave has programmable wait states. Every accepted request pushes
// its expected response to a queue, and a monitor pops and compares each
// resp_valid pulse against that queue.
module tb_axil_req_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;

    logic              aclk;
    logic              aresetn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ-1:0]   resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_code;
    logic              busy;
    logic [AW-1:0]     m_axi_awaddr;
    logic [2:0]        m_axi_awprot;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [31:0]       m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [AW-1:0]     m_axi_araddr;
    logic [2:0]        m_axi_arprot;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [31:0]       m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    axil_req_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_code(resp_code),
        .busy(busy),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_count = 0;

    // Slave configuration and handshake counters.
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    logic [31:0] slave_rdata = '0;
    logic [1:0]  slave_rresp = '0;
    logic [1:0]  slave_bresp = '0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic [1:0]  code;
        int          acc;
        int          lat;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] s_data;
        logic [1:0]  s_resp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_code;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Count the cycles and the handshakes completed on each channel.
    always @(posedge aclk) begin
        cyc++;
        if (!aresetn) begin
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) aw_hs++;
            if (m_axi_wvalid && m_axi_wready)   w_hs++;
            if (m_axi_bvalid && m_axi_bready)   b_hs++;
            if (m_axi_arvalid && m_axi_arready) ar_hs++;
            if (m_axi_rvalid && m_axi_rready)   r_hs++;
        end
    end

    // Behavioural slave that drives its ready and valid signals on the falling edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_delay); aw_wait++; end
            else begin m_axi_awready = 0; aw_wait = 0; end
            if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_delay); w_wait++; end
            else begin m_axi_wready = 0; w_wait = 0; end
            if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= ar_delay); ar_wait++; end
            else begin m_axi_arready = 0; ar_wait = 0; end
            if (aw_hs > b_hs && w_hs > b_hs) begin m_axi_bvalid = (b_wait >= b_delay); b_wait++; end
            else begin m_axi_bvalid = 0; b_wait = 0; end
            if (ar_hs > r_hs) begin m_axi_rvalid = (r_wait >= r_delay); r_wait++; end
            else begin m_axi_rvalid = 0; r_wait = 0; end
        end
        m_axi_bresp = slave_bresp;
        m_axi_rresp = slave_rresp;
        m_axi_rdata = slave_rdata;
    end

    // Response monitor: pop and compare each pulse, and print one line per transaction.
    always @(negedge aclk) begin
        if (aresetn && resp_valid != '0) begin
            resp_count++;
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_onehot", 64'(resp_valid), 64'(4'b0001 << mon_e.idx));
                check("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
                check("resp_code", 64'(resp_code), 64'(mon_e.code));
                if (mon_e.lat >= 0) check("resp_latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                $display("txn req%0d rdata=%h code=%0d accepted@%0d resp@%0d",
                         mon_e.idx, resp_rdata, resp_code, mon_e.acc, cyc);
            end
        end
    end

    task automatic issue(input int idx, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_code, input int lat);
        bit got;
        sb_t e;
        got = 0;
        @(negedge aclk);
        req_valid[idx] = 1'b1;
        req_write[idx] = wr;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*32 +: 32] = data;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (req_ready[idx]) begin got = 1; break; end
            @(negedge aclk);
        end
        check("accepted", 64'(got), 64'd1);
        if (got) begin
            e.idx = idx; e.rdata = exp_rdata; e.code = exp_code; e.acc = cyc; e.lat = lat;
            sb.push_back(e);
            @(posedge aclk);
            #1;
        end
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) begin
            @(negedge aclk);
            #2;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(negedge aclk);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_outputs", {busy, resp_valid, req_ready, m_axi_awvalid, m_axi_wvalid,
                              m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
        check("rst_data", {m_axi_awaddr, m_axi_wdata}, 64'd0);
        check("rst_resp", {m_axi_araddr, resp_rdata, resp_code}, 64'd0);
        aresetn = 1'b1;
    endtask

    initial begin
        int b0;
        int prev;
        logic [NREQ-1:0] exp_oh;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        aresetn = 1'b0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
        m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;

        //          idx wr addr          wdata         slave data    resp   exp rdata     exp code
        vecs[0] = '{1, 1, 32'h4000_0010, 32'hA5A5_0001, 32'hFFFF_FFFF, 2'd0, 32'h0,         2'd0};
        vecs[1] = '{0, 0, 32'h4000_0000, 32'h0,         32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 2'd0};
        vecs[2] = '{3, 1, 32'h4000_0030, 32'h1234_5678, 32'hFFFF_FFFF, 2'd1, 32'h0,         2'd1};
        vecs[3] = '{2, 0, 32'h4000_0024, 32'h0,         32'hCAFE_F00D, 2'd3, 32'hCAFE_F00D, 2'd3};
        vecs[4] = '{0, 1, 32'h4000_0100, 32'h0BAD_CAFE, 32'h1111_2222, 2'd0, 32'h0,         2'd0};
        vecs[5] = '{3, 0, 32'h4000_0040, 32'h0,         32'h0000_0000, 2'd2, 32'h0,         2'd2};

        do_reset();

        // Zero-wait table: check the AXI payload one cycle after acceptance and the
        // response three cycles after acceptance.
        for (int v = 0; v < 6; v++) begin
            slave_rdata = vecs[v].s_data;
            slave_rresp = vecs[v].s_resp;
            slave_bresp = vecs[v].s_resp;
            issue(vecs[v].idx, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                  vecs[v].exp_rdata, vecs[v].exp_code, 3);
            @(negedge aclk);
            if (vecs[v].wr) begin
                check("aw_w_valid", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 64'b110);
                check("awaddr", 64'(m_axi_awaddr), 64'(vecs[v].addr));
                check("wdata", 64'(m_axi_wdata), 64'(vecs[v].wdata));
                check("wstrb_prot", {m_axi_wstrb, m_axi_awprot}, {4'hF, 3'b000});
            end else begin
                check("ar_valid", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 64'b001);
                check("araddr", 64'(m_axi_araddr), 64'(vecs[v].addr));
            end
            wait_drain();
        end

        // Read with wait states: arready is 2 cycles late and rvalid is 3 cycles late.
        ar_delay = 2; r_delay = 3; slave_rdata = 32'h1234_5678; slave_rresp = 2'd0;
        issue(2, 0, 32'h4000_0020, 32'h0, 32'h1234_5678, 2'd0, 8);
        wait_drain();
        ar_delay = 0; r_delay = 0;

        // Split write: W completes 4 cycles before AW.
        aw_delay = 4; w_delay = 0; slave_bresp = 2'd0;
        b0 = aw_hs;
        issue(1, 1, 32'h4000_0050, 32'h5A5A_5A5A, 32'h0, 2'd0, 7);
        @(negedge aclk);
        @(negedge aclk);
        check("split_w_dropped", {m_axi_awvalid, m_axi_wvalid}, 64'b10);
        wait_drain();
        check("split_hs_counts", {32'(aw_hs - b0), 32'(w_hs - b0)}, {32'd1, 32'd1});
        check("split_b_count", 64'(b_hs - b0), 64'd1);
        aw_delay = 0;

        // Error response, followed by a normal request.
        slave_bresp = 2'b10;
        issue(0, 1, 32'h4000_0060, 32'h0000_00EE, 32'h0, 2'b10, 3);
        wait_drain();
        slave_bresp = 2'b00; slave_rresp = 2'b00; slave_rdata = 32'h7777_8888;
        issue(3, 0, 32'h4000_0064, 32'h0, 32'h7777_8888, 2'b00, 3);
        wait_drain();

        // All four requesters held valid for 8 grants, starting from reset.
        do_reset();
        slave_rdata = 32'h5555_AAAA; slave_rresp = 2'd0;
        @(negedge aclk);
        for (int i = 0; i < NREQ; i++) begin
            req_write[i] = 1'b0;
            req_addr[i*AW +: AW] = 32'h4000_0200 + 32'(i * 4);
        end
        req_valid = '1;
        prev = 0;
        for (int k = 0; k < 8; k++) begin
            int found;
            sb_t e;
            found = 0;
            for (int t = 0; t < 20; t++) begin
                #1;
                if (req_ready != '0) begin found = 1; break; end
                @(negedge aclk);
            end
`ifdef AXIL_ARB_FIXED_PRIO_EN
            e.idx = 0;
`else
            e.idx = k % NREQ;
`endif
            exp_oh = NREQ'(1) << e.idx;
            check("rr_found", 64'(found), 64'd1);
            check("rr_grant", 64'(req_ready), 64'(exp_oh));
            if (k > 0) check("rr_spacing", 64'(cyc - prev), 64'd3);
            prev = cyc;
            e.rdata = 32'h5555_AAAA; e.code = 2'd0; e.acc = cyc; e.lat = 3;
            sb.push_back(e);
            @(posedge aclk);
            #1;
            if (k == 7) req_valid = '0;
            @(negedge aclk);
        end
        wait_drain();

        // Reset while the FSM waits in RD_DATA.
        r_delay = 20; slave_rdata = 32'h9999_0000;
        issue(1, 0, 32'h4000_0300, 32'h0, 32'h9999_0000, 2'd0, -1);
        b0 = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge aclk);
            if (m_axi_rready) begin b0 = 1; break; end
        end
        check("reached_rd_data", 64'(b0), 64'd1);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        check("midrst_ctrl", {busy, resp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                              m_axi_arvalid, m_axi_rready}, 64'd0);
        check("midrst_data", {m_axi_araddr, resp_rdata, resp_code}, 64'd0);
        sb.delete();
        b0 = resp_count;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        r_delay = 0;
        repeat (10) @(negedge aclk);
        check("midrst_no_resp", 64'(resp_count - b0), 64'd0);
        slave_rdata = 32'hFEED_0001;
        issue(1, 0, 32'h4000_0304, 32'h0, 32'hFEED_0001, 2'd0, 3);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so that the bench always terminates.
    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
